// File: rtl/adsr_env_pkg.sv
// Shared definitions for the ADSR envelope generator: state encodings,
// accumulator width and the sustain-level helper.
package adsr_env_pkg;

  localparam int ACC_W = 16;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [ACC_W-1:0] ACC_MIN = '0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_t;

  // The sustain parameter addresses the upper byte of the accumulator.
  function automatic logic [ACC_W-1:0] sustain_level(input logic [7:0] s);
    return {s, 8'h00};
  endfunction

endpackage

// File: rtl/adsr_env_if.sv
// Parameter/gate inputs and envelope outputs of the envelope generator.
// The register block / bench side is the master, the generator the slave.
interface adsr_env_if;

  logic [7:0] adsr_ai;
  logic [7:0] adsr_di;
  logic [7:0] adsr_s;
  logic [7:0] adsr_ri;
  logic       trig;
  logic       mute;
  logic [7:0] env;
  logic       active;

  modport master (
    output adsr_ai, adsr_di, adsr_s, adsr_ri, trig, mute,
    input  env, active
  );

  modport slave (
    input  adsr_ai, adsr_di, adsr_s, adsr_ri, trig, mute,
    output env, active
  );

endinterface

// File: rtl/adsr_tick.sv
// Envelope step prescaler: a one-cycle tick every TICK_DIV clocks.
// The count restarts at zero on reset, so the first tick after reset
// release arrives TICK_DIV cycles later (every cycle when TICK_DIV = 1).
module adsr_tick #(
  parameter int TICK_DIV = 256
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_LAST);

  // Free-running modulo-TICK_DIV counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adsr_env.sv
// ADSR envelope generator: trig edge detection, five-state envelope FSM
// with a saturating 16-bit accumulator stepped on prescaler ticks, and
// registered env/active outputs.
module adsr_env
  import adsr_env_pkg::*;
#(
  parameter int TICK_DIV = 256
) (
  input  logic        clk,
  input  logic        rst,
  adsr_env_if.slave   bus
);

  logic tick;

  adsr_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [ACC_W-1:0] acc;
  adsr_state_t      state;
  logic             trig_q;
  logic [7:0]       env_q;
  logic             active_q;

  logic             rise;
  logic             gate_off;
  logic [ACC_W-1:0] sus_lvl;
  logic [ACC_W:0]   atk_sum;
  logic [ACC_W:0]   dec_diff;
  logic [ACC_W:0]   rel_diff;

  assign rise    = bus.trig & ~trig_q;
  assign sus_lvl = sustain_level(bus.adsr_s);

  // A released gate only ends the note from the sounding states; IDLE and
  // RELEASE are unaffected.
  assign gate_off = ~bus.trig &
                    ((state == ATTACK) || (state == DECAY) || (state == SUSTAIN));

  // 17-bit arithmetic: bit 16 is the carry (attack) or borrow (decay/release)
  // and drives saturation, so acc never wraps.
  assign atk_sum  = {1'b0, acc} + {9'd0, bus.adsr_ai};
  assign dec_diff = {1'b0, acc} - {9'd0, bus.adsr_di};
  assign rel_diff = {1'b0, acc} - {9'd0, bus.adsr_ri};

  // Envelope FSM and accumulator; edge and gate-off take priority over steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      state  <= IDLE;
      trig_q <= 1'b0;
    end else begin
      trig_q <= bus.trig;
      if (rise) begin
        // Retrigger from the current level; no step in the edge cycle.
        state <= ATTACK;
      end else if (gate_off) begin
        state <= RELEASE;
      end else begin
        case (state)
          IDLE: begin
            acc <= ACC_MIN;
          end
          ATTACK: begin
            if (tick) begin
              if (atk_sum[ACC_W] || (atk_sum[ACC_W-1:0] == ACC_MAX)) begin
                acc   <= ACC_MAX;
                state <= DECAY;
              end else begin
                acc <= atk_sum[ACC_W-1:0];
              end
            end
          end
          DECAY: begin
            if (tick) begin
              if (dec_diff[ACC_W] || (dec_diff[ACC_W-1:0] <= sus_lvl)) begin
                acc   <= sus_lvl;
                state <= SUSTAIN;
              end else begin
                acc <= dec_diff[ACC_W-1:0];
              end
            end
          end
          SUSTAIN: begin
            // Track the live sustain parameter every cycle, not just on ticks.
            acc <= sus_lvl;
          end
          RELEASE: begin
            if (tick) begin
              if (rel_diff[ACC_W] || (rel_diff[ACC_W-1:0] == ACC_MIN)) begin
                acc   <= ACC_MIN;
                state <= IDLE;
              end else begin
                acc <= rel_diff[ACC_W-1:0];
              end
            end
          end
          default: begin
            acc   <= ACC_MIN;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Output registers: env follows acc's top byte one clock later, muted to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env_q    <= 8'h00;
      active_q <= 1'b0;
    end else begin
      env_q    <= bus.mute ? 8'h00 : acc[ACC_W-1 -: 8];
      active_q <= (state != IDLE);
    end
  end

  assign bus.env    = env_q;
  assign bus.active = active_q;

endmodule

// File: tb/tb_adsr_env.sv
// Scoreboard bench for adsr_env with TICK_DIV = 1. Stimulus pushes
// hand-computed expectations tagged with the cycle they are due; a monitor
// on the falling edge pops and compares them against env/active.
module tb_adsr_env;

  logic clk;
  logic rst;

  adsr_env_if bus();

  adsr_env #(
    .TICK_DIV (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int    when;
    string name;
    int    env_v;   // -1: not checked
    int    act_v;   // -1: not checked
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  int b, r, a, r2, m0, q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int when, input string name, input int env_v, input int act_v);
    exp_t e;
    e.when  = when;
    e.name  = name;
    e.env_v = env_v;
    e.act_v = act_v;
    sb_q.push_back(e);
  endtask

  // Monitor: compare every expectation that has come due at this falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].when <= cyc) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (mon_e.when != cyc) begin
        errors++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", mon_e.name, cyc, mon_e.when);
      end else if ((mon_e.env_v >= 0 && bus.env !== 8'(mon_e.env_v)) ||
                   (mon_e.act_v >= 0 && bus.active !== 1'(mon_e.act_v))) begin
        errors++;
        $display("FAIL %s cyc=%0d: env=%02h active=%0b, required env=%0s active=%0s",
                 mon_e.name, cyc, bus.env, bus.active,
                 (mon_e.env_v >= 0) ? $sformatf("%02h", mon_e.env_v) : "-",
                 (mon_e.act_v >= 0) ? $sformatf("%0d", mon_e.act_v) : "-");
      end else begin
        $display("ok   %-18s cyc=%0d env=%02h active=%0b", mon_e.name, cyc, bus.env, bus.active);
      end
    end
  end

  initial begin
    bus.adsr_ai = 8'h80;
    bus.adsr_di = 8'h40;
    bus.adsr_s  = 8'h80;
    bus.adsr_ri = 8'h20;
    bus.trig    = 1'b0;
    bus.mute    = 1'b0;
    rst         = 1'b1;

    @(negedge clk);
    expect_at(cyc + 1, "reset_state", 8'h00, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Attack from 0 with ai=0x80, decay to sustain 0x80 with di=0x40.
    b = cyc;
    bus.trig = 1'b1;
    expect_at(b + 1,    "atk_edge",      8'h00, 0);
    expect_at(b + 2,    "atk_active",    8'h00, 1);
    expect_at(b + 4,    "atk_step",      8'h01, 1);
    expect_at(b + 257,  "atk_mid",       8'h7F, 1);
    expect_at(b + 511,  "atk_pre_sat",   8'hFE, 1);
    expect_at(b + 514,  "atk_sat",       8'hFF, 1);
    expect_at(b + 770,  "decay_mid",     8'hBF, 1);
    expect_at(b + 1100, "sustain_hold",  8'h80, 1);
    repeat (1100) @(negedge clk);

    // Live sustain change shows two cycles later.
    bus.adsr_s = 8'h40;
    expect_at(b + 1101, "sus_chg_lag",   8'h80, 1);
    expect_at(b + 1102, "sus_chg_live",  8'h40, 1);
    repeat (5) @(negedge clk);
    bus.adsr_s = 8'h80;
    expect_at(b + 1106, "sus_low_hold",  8'h40, 1);
    expect_at(b + 1107, "sus_restore",   8'h80, 1);
    repeat (5) @(negedge clk);

    // Release from 0x8000 with ri=0x20, retrigger at 0x4000.
    r = cyc;
    bus.trig = 1'b0;
    expect_at(r + 2,   "rel_first",      8'h80, 1);
    expect_at(r + 3,   "rel_step",       8'h7F, 1);
    expect_at(r + 514, "rel_half",       8'h40, 1);
    repeat (513) @(negedge clk);
    a = cyc;
    bus.trig = 1'b1;
    expect_at(a + 2,   "retrig_hold",    8'h40, 1);
    expect_at(a + 3,   "retrig_nodrop",  8'h40, 1);
    expect_at(a + 4,   "retrig_step",    8'h41, 1);
    expect_at(a + 900, "resustain",      8'h80, 1);
    repeat (950) @(negedge clk);

    // Full release to IDLE.
    r2 = cyc;
    bus.trig = 1'b0;
    expect_at(r2 + 514,  "rel2_half",    8'h40, 1);
    expect_at(r2 + 1025, "rel2_last",    8'h00, 1);
    expect_at(r2 + 1026, "rel2_idle",    8'h00, 0);
    repeat (1100) @(negedge clk);

    // Zero attack increment holds the level; mute in both directions.
    m0 = cyc;
    bus.trig = 1'b1;
    expect_at(m0 + 1, "atk2_edge",       8'h00, 0);
    expect_at(m0 + 4, "atk2_step",       8'h01, 1);
    repeat (10) @(negedge clk);
    bus.adsr_ai = 8'h00;
    expect_at(m0 + 11,  "ai_zero_start", 8'h04, 1);
    expect_at(m0 + 60,  "ai_zero_hold",  8'h04, 1);
    expect_at(m0 + 100, "pre_mute",      8'h04, 1);
    repeat (90) @(negedge clk);
    bus.mute = 1'b1;
    expect_at(m0 + 101, "mute_on",       8'h00, 1);
    expect_at(m0 + 110, "mute_held",     8'h00, 1);
    repeat (10) @(negedge clk);
    bus.mute = 1'b0;
    expect_at(m0 + 111, "mute_off",      8'h04, 1);
    repeat (89) @(negedge clk);

    // Resume attack, then reset asynchronously mid-attack with trig held.
    bus.adsr_ai = 8'h80;
    expect_at(m0 + 260, "atk_resume",    8'h22, 1);
    repeat (99) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    expect_at(m0 + 300, "rst_async",     8'h00, 0);
    expect_at(m0 + 302, "rst_hold",      8'h00, 0);
    repeat (3) @(negedge clk);
    q = cyc;
    rst = 1'b0;
    expect_at(q + 1,  "rst_rel_edge",    8'h00, 0);
    expect_at(q + 2,  "rst_rel_active",  8'h00, 1);
    expect_at(q + 4,  "rst_restart",     8'h01, 1);
    expect_at(q + 10, "rst_restart_b",   8'h04, 1);
    repeat (20) @(negedge clk);

    // Anything still queued was never compared.
    for (int i = 0; i < 50 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
